// File: rtl/mux_scan_ctrl.sv
// Parallel-to-serial scan sequencer feeding an 8:1 mux: latches a word onto x_o and steps a_o.
// Define MUX_SCAN_MSB_FIRST_EN to scan from index DATA_W-1 down to 0 instead of 0 up.
module mux_scan_ctrl #(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              step_en_i,
  output logic [DATA_W-1:0] x_o,
  output logic [SEL_W-1:0]  a_o,
  output logic              busy_o,
  output logic              bit_valid_o,
  output logic              done_o
);

  if (DATA_W != (1 << SEL_W)) begin : g_width_check
    $error("mux_scan_ctrl: DATA_W must equal 2**SEL_W");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

`ifdef MUX_SCAN_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FirstIdx = SEL_W'(DATA_W - 1);
  localparam logic [SEL_W-1:0] LastIdx  = '0;
`else
  localparam logic [SEL_W-1:0] FirstIdx = '0;
  localparam logic [SEL_W-1:0] LastIdx  = SEL_W'(DATA_W - 1);
`endif

  state_e             state_q;
  logic [DATA_W-1:0]  x_q;
  logic [SEL_W-1:0]   a_q;
  logic               busy_q;
  logic               bit_valid_q;
  logic               done_q;
  logic [SEL_W-1:0]   a_next;

`ifdef MUX_SCAN_MSB_FIRST_EN
  assign a_next = a_q - 1'b1;
`else
  assign a_next = a_q + 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      x_q         <= '0;
      a_q         <= FirstIdx;
      busy_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // step_en_i alongside start_i is deliberately ignored: the scan opens on FirstIdx.
          if (start_i) begin
            x_q         <= din_i;
            a_q         <= FirstIdx;
            busy_q      <= 1'b1;
            bit_valid_q <= 1'b1;
            state_q     <= StScan;
          end
        end
        StScan: begin
          if (step_en_i) begin
            if (a_q == LastIdx) begin
              a_q         <= FirstIdx;
              busy_q      <= 1'b0;
              bit_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              a_q <= a_next;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign x_o         = x_q;
  assign a_o         = a_q;
  assign busy_o      = busy_q;
  assign bit_valid_o = bit_valid_q;
  assign done_o      = done_q;

endmodule
